// File: rtl/rename_unit.sv
// rename_unit: register-rename stage between decode and dispatch of the
// dual-issue core. Holds the speculative RAT, the architectural RAT and the
// physical-register free list. It also rebuilds speculative state from the
// ROB rollback/walk stream after a flush.
//
// Ports:
//    clk, reset_n              clock, asynchronous active-low reset
//    instrN_*                  rename requests (slot 0 older), sources/dest
//    instrN_ps1/ps2/T/T_old    renamed sources, new tag, previous mapping
//    rename_ready              requests accepted this cycle
//    fl_left                   free-list occupancy: 00 empty, 01 one, 10 two+
//    retireN_*                 ROB retire stream (commit mapping, free T_old)
//    rob_state                 0 idle, 1 rollback, 2 walk (common package encoding)
//    walkN_*                   surviving entries replayed during walk
module rename_unit #(
   parameter int ARF_NUM   = 32,
   parameter int ARF_WIDTH = 5,
   parameter int PRF_NUM   = 64,
   parameter int PRF_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 instr0_valid,
   input  logic                 instr0_is_wb,
   input  logic [ARF_WIDTH-1:0] instr0_rs1,
   input  logic [ARF_WIDTH-1:0] instr0_rs2,
   input  logic [ARF_WIDTH-1:0] instr0_rd,
   input  logic                 instr1_valid,
   input  logic                 instr1_is_wb,
   input  logic [ARF_WIDTH-1:0] instr1_rs1,
   input  logic [ARF_WIDTH-1:0] instr1_rs2,
   input  logic [ARF_WIDTH-1:0] instr1_rd,
   output logic [PRF_WIDTH-1:0] instr0_ps1,
   output logic [PRF_WIDTH-1:0] instr0_ps2,
   output logic [PRF_WIDTH-1:0] instr0_T,
   output logic [PRF_WIDTH-1:0] instr0_T_old,
   output logic [PRF_WIDTH-1:0] instr1_ps1,
   output logic [PRF_WIDTH-1:0] instr1_ps2,
   output logic [PRF_WIDTH-1:0] instr1_T,
   output logic [PRF_WIDTH-1:0] instr1_T_old,
   output logic                 rename_ready,
   output logic [1:0]           fl_left,
   input  logic                 retire0_valid,
   input  logic                 retire0_is_wb,
   input  logic [ARF_WIDTH-1:0] retire0_arf_id,
   input  logic [PRF_WIDTH-1:0] retire0_T,
   input  logic [PRF_WIDTH-1:0] retire0_fl_Told,
   input  logic                 retire1_valid,
   input  logic                 retire1_is_wb,
   input  logic [ARF_WIDTH-1:0] retire1_arf_id,
   input  logic [PRF_WIDTH-1:0] retire1_T,
   input  logic [PRF_WIDTH-1:0] retire1_fl_Told,
   input  logic [1:0]           rob_state,
   input  logic                 walk0_valid,
   input  logic [ARF_WIDTH-1:0] walk0_arf_id,
   input  logic [PRF_WIDTH-1:0] walk0_T,
   input  logic                 walk1_valid,
   input  logic [ARF_WIDTH-1:0] walk1_arf_id,
   input  logic [PRF_WIDTH-1:0] walk1_T
);

   localparam logic [1:0] ROB_IDLE     = 2'd0;
   localparam logic [1:0] ROB_ROLLBACK = 2'd1;
   localparam logic [1:0] ROB_WALK     = 2'd2;

   localparam int FL_CAP = PRF_NUM - ARF_NUM;
   localparam int PW     = PRF_WIDTH + 1;

   logic [PRF_WIDTH-1:0] spec_rat  [ARF_NUM];
   logic [PRF_WIDTH-1:0] arch_rat  [ARF_NUM];
   logic [PRF_WIDTH-1:0] spec_next [ARF_NUM];
   logic [PRF_WIDTH-1:0] arch_next [ARF_NUM];
   logic [PRF_WIDTH-1:0] fl        [PRF_NUM];

   logic [PW-1:0] fl_wr, fl_rd, fl_arch_rd, fl_rd_next, count;
   logic [PW-1:0] n_alloc, n_ret, n_walk;
   logic          alloc0, alloc1, ret_wr0, ret_wr1, walk_hit0, walk_hit1;
   logic          is_idle, is_rb, is_walk;
   logic [PRF_WIDTH-1:0] rd_idx0, rd_idx1, wr_idx0, wr_idx1, tag0, tag1;
   logic [PRF_WIDTH-1:0] walk_exp0, walk_exp1;

   assign is_idle = (rob_state == ROB_IDLE);
   assign is_rb   = (rob_state == ROB_ROLLBACK);
   assign is_walk = (rob_state == ROB_WALK);

   // x0 is hard-wired, so it never consumes a tag
   assign alloc0  = instr0_valid & instr0_is_wb & (instr0_rd != '0);
   assign alloc1  = instr1_valid & instr1_is_wb & (instr1_rd != '0);
   assign n_alloc = PW'(alloc0) + PW'(alloc1);

   assign ret_wr0 = retire0_valid & retire0_is_wb & (retire0_arf_id != '0);
   assign ret_wr1 = retire1_valid & retire1_is_wb & (retire1_arf_id != '0);
   assign n_ret   = PW'(ret_wr0) + PW'(ret_wr1);

   assign walk_hit0 = walk0_valid & (walk0_arf_id != '0);
   assign walk_hit1 = walk1_valid & (walk1_arf_id != '0);
   assign n_walk    = PW'(walk_hit0) + PW'(walk_hit1);

   assign count   = fl_wr - fl_rd;
   assign rd_idx0 = fl_rd[PRF_WIDTH-1:0];
   assign rd_idx1 = rd_idx0 + PRF_WIDTH'(alloc0);
   assign wr_idx0 = fl_wr[PRF_WIDTH-1:0];
   assign wr_idx1 = wr_idx0 + PRF_WIDTH'(ret_wr0);
   assign tag0    = fl[rd_idx0];
   assign tag1    = fl[rd_idx1];

   assign rename_ready = is_idle & (count >= n_alloc);
   assign fl_left      = (count == '0) ? 2'b00 : (count == PW'(1)) ? 2'b01 : 2'b10;

   assign instr0_T     = alloc0 ? tag0 : '0;
   assign instr1_T     = alloc1 ? tag1 : '0;
   assign instr0_T_old = alloc0 ? spec_rat[instr0_rd] : '0;
   assign instr0_ps1   = (instr0_rs1 == '0) ? '0 : spec_rat[instr0_rs1];
   assign instr0_ps2   = (instr0_rs2 == '0) ? '0 : spec_rat[instr0_rs2];

   // slot 1 sees slot 0's new mapping within the same pair
   assign instr1_ps1 = (instr1_rs1 == '0) ? '0 :
                       (alloc0 && instr1_rs1 == instr0_rd) ? tag0 : spec_rat[instr1_rs1];
   assign instr1_ps2 = (instr1_rs2 == '0) ? '0 :
                       (alloc0 && instr1_rs2 == instr0_rd) ? tag0 : spec_rat[instr1_rs2];
   assign instr1_T_old = !alloc1 ? '0 :
                         (alloc0 && instr1_rd == instr0_rd) ? tag0 : spec_rat[instr1_rd];

   always_comb begin
      arch_next = arch_rat;
      if (ret_wr0) arch_next[retire0_arf_id] = retire0_T;
      if (ret_wr1) arch_next[retire1_arf_id] = retire1_T;
   end

   // Rollback copies the post-retire architectural view so a retire in the
   // same cycle is not lost; the same holds for the free-list read pointer.
   always_comb begin
      spec_next  = spec_rat;
      fl_rd_next = fl_rd;
      if (is_rb) begin
         spec_next  = arch_next;
         fl_rd_next = fl_arch_rd + n_ret;
      end else if (is_walk) begin
         if (walk_hit0) spec_next[walk0_arf_id] = walk0_T;
         if (walk_hit1) spec_next[walk1_arf_id] = walk1_T;
         fl_rd_next = fl_rd + n_walk;
      end else if (rename_ready) begin
         if (alloc0) spec_next[instr0_rd] = tag0;
         if (alloc1) spec_next[instr1_rd] = tag1;
         fl_rd_next = fl_rd + n_alloc;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ARF_NUM; i++) begin
            spec_rat[i] <= PRF_WIDTH'(i);
            arch_rat[i] <= PRF_WIDTH'(i);
         end
         for (int i = 0; i < PRF_NUM; i++)
            fl[i] <= (i < FL_CAP) ? PRF_WIDTH'(ARF_NUM + i) : '0;
         fl_wr      <= PW'(FL_CAP);
         fl_rd      <= '0;
         fl_arch_rd <= '0;
      end else begin
         spec_rat   <= spec_next;
         arch_rat   <= arch_next;
         fl_rd      <= fl_rd_next;
         fl_arch_rd <= fl_arch_rd + n_ret;
         fl_wr      <= fl_wr + n_ret;
         if (ret_wr0) fl[wr_idx0] <= retire0_fl_Told;
         if (ret_wr1) fl[wr_idx1] <= retire1_fl_Told;
      end
   end

   // replayed tags must come back in allocation order
   assign walk_exp0 = fl[rd_idx0];
   assign walk_exp1 = fl[rd_idx0 + PRF_WIDTH'(walk_hit0)];

   a_count_cap: assert property (@(posedge clk) disable iff (!reset_n)
      count <= PW'(FL_CAP));
   a_fl_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      ({1'b0, count} + {1'b0, n_ret}) <= (PW+1)'(PRF_NUM));
   a_walk0_tag: assert property (@(posedge clk) disable iff (!reset_n)
      (is_walk && walk_hit0) |-> (walk0_T == walk_exp0));
   a_walk1_tag: assert property (@(posedge clk) disable iff (!reset_n)
      (is_walk && walk_hit1) |-> (walk1_T == walk_exp1));

endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;

   localparam logic [1:0] ROB_IDLE     = 2'd0;
   localparam logic [1:0] ROB_ROLLBACK = 2'd1;
   localparam logic [1:0] ROB_WALK     = 2'd2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       instr0_valid, instr0_is_wb, instr1_valid, instr1_is_wb;
   logic [4:0] instr0_rs1, instr0_rs2, instr0_rd, instr1_rs1, instr1_rs2, instr1_rd;
   logic [5:0] instr0_ps1, instr0_ps2, instr0_T, instr0_T_old;
   logic [5:0] instr1_ps1, instr1_ps2, instr1_T, instr1_T_old;
   logic       rename_ready;
   logic [1:0] fl_left;
   logic       retire0_valid, retire0_is_wb, retire1_valid, retire1_is_wb;
   logic [4:0] retire0_arf_id, retire1_arf_id;
   logic [5:0] retire0_T, retire0_fl_Told, retire1_T, retire1_fl_Told;
   logic [1:0] rob_state;
   logic       walk0_valid, walk1_valid;
   logic [4:0] walk0_arf_id, walk1_arf_id;
   logic [5:0] walk0_T, walk1_T;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rename_unit dut (
      .clk(clk), .reset_n(reset_n),
      .instr0_valid(instr0_valid), .instr0_is_wb(instr0_is_wb),
      .instr0_rs1(instr0_rs1), .instr0_rs2(instr0_rs2), .instr0_rd(instr0_rd),
      .instr1_valid(instr1_valid), .instr1_is_wb(instr1_is_wb),
      .instr1_rs1(instr1_rs1), .instr1_rs2(instr1_rs2), .instr1_rd(instr1_rd),
      .instr0_ps1(instr0_ps1), .instr0_ps2(instr0_ps2),
      .instr0_T(instr0_T), .instr0_T_old(instr0_T_old),
      .instr1_ps1(instr1_ps1), .instr1_ps2(instr1_ps2),
      .instr1_T(instr1_T), .instr1_T_old(instr1_T_old),
      .rename_ready(rename_ready), .fl_left(fl_left),
      .retire0_valid(retire0_valid), .retire0_is_wb(retire0_is_wb),
      .retire0_arf_id(retire0_arf_id), .retire0_T(retire0_T),
      .retire0_fl_Told(retire0_fl_Told),
      .retire1_valid(retire1_valid), .retire1_is_wb(retire1_is_wb),
      .retire1_arf_id(retire1_arf_id), .retire1_T(retire1_T),
      .retire1_fl_Told(retire1_fl_Told),
      .rob_state(rob_state),
      .walk0_valid(walk0_valid), .walk0_arf_id(walk0_arf_id), .walk0_T(walk0_T),
      .walk1_valid(walk1_valid), .walk1_arf_id(walk1_arf_id), .walk1_T(walk1_T)
   );

   typedef struct {
      logic       i0v, i0wb;
      logic [4:0] i0rs1, i0rs2, i0rd;
      logic       i1v, i1wb;
      logic [4:0] i1rs1, i1rs2, i1rd;
      logic [5:0] e_ps1_0, e_ps2_0, e_T0, e_Told0;
      logic [5:0] e_ps1_1, e_ps2_1, e_T1, e_Told1;
      logic       e_rdy;
      logic [1:0] e_left;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drv0(input logic v, input logic wb, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
      instr0_valid = v; instr0_is_wb = wb;
      instr0_rs1 = rs1; instr0_rs2 = rs2; instr0_rd = rd;
   endtask

   task automatic drv1(input logic v, input logic wb, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
      instr1_valid = v; instr1_is_wb = wb;
      instr1_rs1 = rs1; instr1_rs2 = rs2; instr1_rd = rd;
   endtask

   task automatic ret0(input logic v, input logic [4:0] arf, input logic [5:0] t,
                       input logic [5:0] told);
      retire0_valid = v; retire0_is_wb = v; retire0_arf_id = arf;
      retire0_T = t; retire0_fl_Told = told;
   endtask

   task automatic ret1(input logic v, input logic [4:0] arf, input logic [5:0] t,
                       input logic [5:0] told);
      retire1_valid = v; retire1_is_wb = v; retire1_arf_id = arf;
      retire1_T = t; retire1_fl_Told = told;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd1, 5'd2, 5'd5,  1'b1, 1'b1, 5'd3, 5'd4, 5'd6,
                  6'd1, 6'd2, 6'd32, 6'd5,  6'd3, 6'd4, 6'd33, 6'd6, 1'b1, 2'd2};
      vecs[1] = '{1'b1, 1'b1, 5'd5, 5'd6, 5'd7,  1'b1, 1'b1, 5'd7, 5'd5, 5'd7,
                  6'd32, 6'd33, 6'd34, 6'd7,  6'd34, 6'd32, 6'd35, 6'd34, 1'b1, 2'd2};
      vecs[2] = '{1'b1, 1'b0, 5'd7, 5'd0, 5'd8,  1'b1, 1'b1, 5'd11, 5'd6, 5'd0,
                  6'd35, 6'd0, 6'd0, 6'd0,  6'd11, 6'd33, 6'd0, 6'd0, 1'b1, 2'd2};
      vecs[3] = '{1'b1, 1'b1, 5'd0, 5'd7, 5'd9,  1'b0, 1'b1, 5'd9, 5'd0, 5'd9,
                  6'd0, 6'd35, 6'd36, 6'd9,  6'd36, 6'd0, 6'd0, 6'd0, 1'b1, 2'd2};
      vecs[4] = '{1'b0, 1'b1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b1, 5'd9, 5'd10, 5'd10,
                  6'd32, 6'd0, 6'd0, 6'd0,  6'd36, 6'd10, 6'd37, 6'd10, 1'b1, 2'd2};
      vecs[5] = '{1'b1, 1'b1, 5'd7, 5'd10, 5'd11, 1'b1, 1'b1, 5'd10, 5'd11, 5'd11,
                  6'd35, 6'd37, 6'd38, 6'd11,  6'd37, 6'd38, 6'd39, 6'd38, 1'b1, 2'd2};

      reset_n = 1'b0;
      rob_state = ROB_IDLE;
      drv0(1'b0, 1'b0, 5'd3, 5'd0, 5'd0);
      drv1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      ret0(1'b0, 5'd0, 6'd0, 6'd0);
      ret1(1'b0, 5'd0, 6'd0, 6'd0);
      walk0_valid = 1'b0; walk0_arf_id = '0; walk0_T = '0;
      walk1_valid = 1'b0; walk1_arf_id = '0; walk1_T = '0;
      #12;
      chk("reset_ready", rename_ready, 1);
      chk("reset_fl_left", fl_left, 2);
      chk("reset_T0", instr0_T, 0);
      chk("reset_Told1", instr1_T_old, 0);
      chk("reset_ps_identity", instr0_ps1, 3);
      #1 reset_n = 1'b1;
      tick();

      // table: consecutive renamed pairs starting from reset
      for (int i = 0; i < 6; i++) begin
         drv0(vecs[i].i0v, vecs[i].i0wb, vecs[i].i0rs1, vecs[i].i0rs2, vecs[i].i0rd);
         drv1(vecs[i].i1v, vecs[i].i1wb, vecs[i].i1rs1, vecs[i].i1rs2, vecs[i].i1rd);
         #2;
         chk($sformatf("v%0d_ps1_0", i), instr0_ps1, vecs[i].e_ps1_0);
         chk($sformatf("v%0d_ps2_0", i), instr0_ps2, vecs[i].e_ps2_0);
         chk($sformatf("v%0d_T0", i), instr0_T, vecs[i].e_T0);
         chk($sformatf("v%0d_Told0", i), instr0_T_old, vecs[i].e_Told0);
         chk($sformatf("v%0d_ps1_1", i), instr1_ps1, vecs[i].e_ps1_1);
         chk($sformatf("v%0d_ps2_1", i), instr1_ps2, vecs[i].e_ps2_1);
         chk($sformatf("v%0d_T1", i), instr1_T, vecs[i].e_T1);
         chk($sformatf("v%0d_Told1", i), instr1_T_old, vecs[i].e_Told1);
         chk($sformatf("v%0d_ready", i), rename_ready, vecs[i].e_rdy);
         chk($sformatf("v%0d_fl_left", i), fl_left, vecs[i].e_left);
         tick();
      end

      // rollback restores identity mapping and the whole free list
      drv0(1'b1, 1'b1, 5'd5, 5'd0, 5'd12);
      drv1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      rob_state = ROB_ROLLBACK;
      #2 chk("rollback_blocks_rename", rename_ready, 0);
      tick();
      rob_state = ROB_IDLE;
      drv0(1'b1, 1'b1, 5'd5, 5'd0, 5'd1);
      drv1(1'b1, 1'b1, 5'd0, 5'd0, 5'd2);
      #2;
      chk("rb_restored_ps", instr0_ps1, 5);
      chk("rb_restored_T0", instr0_T, 32);
      chk("rb_restored_T1", instr1_T, 33);
      tick();
      drv0(1'b1, 1'b1, 5'd0, 5'd0, 5'd3);
      drv1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      #2 chk("x3_T0", instr0_T, 34);
      tick();

      // flush: only x1 survives
      drv0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      rob_state = ROB_ROLLBACK;
      tick();
      rob_state = ROB_WALK;
      walk0_valid = 1'b1; walk0_arf_id = 5'd1; walk0_T = 6'd32;
      drv0(1'b1, 1'b1, 5'd0, 5'd0, 5'd4);
      #2 chk("walk_blocks_rename", rename_ready, 0);
      tick();
      walk0_valid = 1'b0;
      rob_state = ROB_IDLE;
      drv0(1'b1, 1'b1, 5'd1, 5'd2, 5'd4);
      drv1(1'b1, 1'b1, 5'd3, 5'd0, 5'd4);
      #2;
      chk("walk_spec_x1", instr0_ps1, 32);
      chk("walk_spec_x2", instr0_ps2, 2);
      chk("walk_spec_x3", instr1_ps1, 3);
      chk("walk_next_alloc", instr0_T, 33);
      chk("x4_pair_T1", instr1_T, 34);
      chk("x4_pair_Told1", instr1_T_old, 33);
      tick();

      // retire x1, then a same-cycle dual retire to x4
      drv0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      drv1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      ret0(1'b1, 5'd1, 6'd32, 6'd1);
      tick();
      ret0(1'b1, 5'd4, 6'd33, 6'd4);
      ret1(1'b1, 5'd4, 6'd34, 6'd33);
      tick();
      ret0(1'b0, 5'd0, 6'd0, 6'd0);
      ret1(1'b0, 5'd0, 6'd0, 6'd0);
      rob_state = ROB_ROLLBACK;
      tick();
      rob_state = ROB_IDLE;
      drv0(1'b0, 1'b0, 5'd4, 5'd1, 5'd0);
      #2;
      chk("arch_x4_slot1_wins", instr0_ps1, 34);
      chk("arch_x1", instr0_ps2, 32);
      chk("fl_full_left", fl_left, 2);

      // drain the free list; the last three tags are the retired T_olds in slot order
      for (int k = 0; k < 32; k++) begin
         logic [5:0] exp_t;
         exp_t = (k < 29) ? 6'(35 + k) : (k == 29) ? 6'd1 : (k == 30) ? 6'd4 : 6'd33;
         drv0(1'b1, 1'b1, 5'd0, 5'd0, 5'(5 + (k % 20)));
         #2;
         chk($sformatf("drain%0d_T0", k), instr0_T, exp_t);
         chk($sformatf("drain%0d_ready", k), rename_ready, 1);
         tick();
      end
      #2;
      chk("empty_fl_left", fl_left, 0);
      chk("empty_ready_with_req", rename_ready, 0);
      drv0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1 chk("empty_ready_no_req", rename_ready, 1);
      drv0(1'b1, 1'b1, 5'd0, 5'd0, 5'd6);
      ret0(1'b1, 5'd5, 6'd35, 6'd5);
      #1;
      chk("retire_no_forward_left", fl_left, 0);
      chk("retire_no_forward_ready", rename_ready, 0);
      tick();
      ret0(1'b0, 5'd0, 6'd0, 6'd0);
      #1;
      chk("one_fl_left", fl_left, 1);
      chk("one_ready", rename_ready, 1);
      chk("one_T0_freed", instr0_T, 5);
      drv1(1'b1, 1'b1, 5'd0, 5'd0, 5'd7);
      #1 chk("one_pair_not_ready", rename_ready, 0);
      drv0(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      drv1(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

      // reset in the middle of a walk
      rob_state = ROB_ROLLBACK;
      tick();
      rob_state = ROB_WALK;
      walk0_valid = 1'b1; walk0_arf_id = 5'd2; walk0_T = 6'd36;
      tick();
      walk0_valid = 1'b0;
      drv0(1'b1, 1'b1, 5'd2, 5'd0, 5'd3);
      #1;
      chk("midwalk_ps", instr0_ps1, 36);
      chk("midwalk_T0", instr0_T, 37);
      reset_n = 1'b0;
      rob_state = ROB_IDLE;
      #1;
      chk("async_reset_ps", instr0_ps1, 2);
      chk("async_reset_T0", instr0_T, 32);
      chk("async_reset_Told0", instr0_T_old, 3);
      chk("async_reset_ready", rename_ready, 1);
      chk("async_reset_fl_left", fl_left, 2);
      #1 reset_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage of the dual-issue superscalar core; sits between decode and dispatch.
- Maintains the speculative RAT, the architectural RAT and the PRF free list.
- Consumes the ROB's retire stream to commit mappings and free T_old tags.
- Consumes the ROB's rollback/walk stream to rebuild speculative state after a flush.

Parameters:
- ARF_NUM, 32, architectural registers.
- ARF_WIDTH, 5, log2(ARF_NUM).
- PRF_NUM, 64, physical registers; power of two.
- PRF_WIDTH, 6, log2(PRF_NUM).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- instrN_valid (N=0,1)  in  1  rename request; slot 0 is older.
- instrN_is_wb  in  1  instruction writes rd.
- instrN_rs1, instrN_rs2, instrN_rd  in  ARF_WIDTH  architectural sources and destination.
- instrN_ps1, instrN_ps2  out  PRF_WIDTH  physical sources.
- instrN_T  out  PRF_WIDTH  newly allocated tag; 0 if no allocation.
- instrN_T_old  out  PRF_WIDTH  previous mapping of rd; 0 if no allocation.
- rename_ready  out  1  requests are accepted this cycle.
- fl_left  out  2  free-list occupancy: 00 empty, 01 one tag, 10 two or more.
- retireN_valid, retireN_is_wb  in  1  ROB retire slot N.
- retireN_arf_id  in  ARF_WIDTH  retiring rd.
- retireN_T  in  PRF_WIDTH  retiring tag.
- retireN_fl_Told  in  PRF_WIDTH  tag to free.
- rob_state  in  2  rob_idle / rob_rollback / rob_walk, as encoded in package common.
- walkN_valid  in  1  replay this surviving entry.
- walkN_arf_id  in  ARF_WIDTH  surviving entry's rd.
- walkN_T  in  PRF_WIDTH  surviving entry's tag.

Behaviour:

Reset (asynchronous, takes effect immediately, including mid-walk):
- spec_rat[i] = i and arch_rat[i] = i.
- Free list holds tags ARF_NUM..PRF_NUM-1 in order; fl_wr = PRF_NUM-ARF_NUM; fl_rd = 0; fl_arch_rd = 0.
- All pointers are PRF_WIDTH+1 bits wide; count = fl_wr - fl_rd.
- Resulting outputs: rename_ready=1, fl_left=10, all tags 0.

Allocation and readiness:
- allocN = instrN_valid & instrN_is_wb & (instrN_rd != 0). x0 is never renamed.
- rename_ready = (rob_state==rob_idle) & (count >= alloc0+alloc1).
- When rename_ready=0: no state update, and dispatch must not take the outputs.

Rename (combinational outputs, state update at the clock edge):
- psX = spec_rat[rsX]; rs==0 always yields 0.
- Slot 0 takes fl[fl_rd]. Slot 1 takes fl[fl_rd+alloc0].
- Intra-pair bypass: if alloc0 and instr1_rsX==instr0_rd, then instr1_psX = instr0_T. If also instr1_rd==instr0_rd, then instr1_T_old = instr0_T.
- On a ready edge: spec_rat updated (slot 1 wins on the same rd); fl_rd += alloc0+alloc1.

Retire (any rob_state):
- A slot counts as a write-retire only if retireN_valid & retireN_is_wb & arf_id!=0.
- For each write-retire: arch_rat[arf_id] <= T (slot 1 wins on conflict); push Told at fl_wr, then slot 1's Told.
- fl_wr and fl_arch_rd each advance by the number of write-retires.
- Freed tags are allocatable the next cycle.
- Retire and rename in the same cycle are both honoured. count uses the pre-edge value, so no same-cycle forwarding.

Recovery:
- rob_rollback cycle: spec_rat <= arch_rat (including any same-cycle retire update, forwarded); fl_rd <= fl_arch_rd (forwarded likewise). Rename is blocked.
- rob_walk cycle: each walkN_valid with arf_id!=0 sets spec_rat[arf_id] <= T (slot 1 wins) and advances fl_rd by 1. Replay in order works because allocation order equals program order.
- A rollback arriving during a walk restarts recovery from arch_rat.

Invariants (assert):
- count <= PRF_NUM-ARF_NUM.
- Free list never overflows.
- walkN_T equals fl[fl_rd] at replay.

Test Plan:
- Reset, then rename add x5 and sub x6 (both is_wb) → T0=32, T1=33, T_old0=5, T_old1=6; next cycle spec_rat[5]=32, fl_left=10.
- Pair with instr0 rd=x7 and instr1 rs1=x7, rd=x7 → instr1_ps1=32, instr1_T=33, instr1_T_old=32.
- Rename 32 write instrs with no retire → count 0, fl_left=00, rename_ready=0; retire one with Told=5 → next cycle fl_left=01, allocation returns 5.
- Rename x1→32, x2→33, x3→34; rollback, then walk0 = {x1, 32} → spec_rat[1]=32, spec_rat[2]=2, spec_rat[3]=3, next allocation is 33.
- Same-cycle dual retire to x4 (T 40, then 41) → arch_rat[4]=41; both Told values pushed in slot order.
- Assert reset_n low mid-walk → outputs return to reset values asynchronously, before the next clock edge.
